// File: rtl/circuit_1_checker.sv
// circuit_1_checker: self-test sweep engine for Circuit_1 (optional CHECKER_STOP_ON_FAIL_EN halts on first mismatch)
module circuit_1_checker #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] EXP_F1        = 8'h00,
    parameter logic [7:0] EXP_F2        = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       F1,
    input  logic       F2,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);
    localparam int SC = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW = (SC > 1) ? $clog2(SC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_vec;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_err;
    logic [7:0]    r_fail;
    logic          w_mis;
    logic          w_last;

    // case-inequality so X/Z on the DUT outputs is flagged as a mismatch
    assign w_mis = (F1 !== EXP_F1[r_vec]) || (F2 !== EXP_F2[r_vec]);
`ifdef CHECKER_STOP_ON_FAIL_EN
    assign w_last = (r_vec == 3'd7) || w_mis;
`else
    assign w_last = (r_vec == 3'd7);
`endif

    assign {A, B, C}  = r_vec;
    assign busy       = (r_state == SETTLE) || (r_state == SAMPLE);
    assign done       = (r_state == DONE);
    assign pass       = done && (r_err == 4'd0);
    assign err_count  = r_err;
    assign fail_vec   = r_fail;

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state: start accepted only when not busy, SAMPLE lasts one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = start ? SETTLE : r_state;
            SETTLE:     w_next = (r_cnt == CNT_LAST) ? SAMPLE : SETTLE;
            SAMPLE:     w_next = w_last ? DONE : SETTLE;
            default:    w_next = IDLE;
        endcase
    end

    // vector index, settle counter and result accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec  <= '0;
            r_cnt  <= '0;
            r_err  <= '0;
            r_fail <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_vec  <= '0;
                        r_cnt  <= '0;
                        r_err  <= '0;
                        r_fail <= '0;
                    end
                end
                SETTLE: r_cnt <= r_cnt + 1'b1;
                SAMPLE: begin
                    if (w_mis) begin
                        r_err         <= r_err + 4'd1;
                        r_fail[r_vec] <= 1'b1;
                    end
                    if (!w_last) begin
                        r_vec <= r_vec + 3'd1;
                        r_cnt <= '0;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_circuit_1_checker.sv
// tb_circuit_1_checker: table-driven sweeps of circuit_1_checker against a Circuit_1 golden model, scoreboarded results
module tb_circuit_1_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       F1, F2;
    logic       A, B, C, busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    logic       f1_tie0 = 1'b0;
    int         f2_bad = -1;
    logic       xv;
    logic       g1, g2;

    int checks = 0;
    int errors = 0;

`ifdef CHECKER_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // Circuit_1 golden: F1 = A&B | C, F2 = A^B^C -> tables 8'hEA / 8'h96
    circuit_1_checker #(.SETTLE_CYCLES(4), .EXP_F1(8'hEA), .EXP_F2(8'h96)) dut (
        .clk(clk), .reset(reset), .start(start), .F1(F1), .F2(F2),
        .A(A), .B(B), .C(C), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    initial xv = 1'bx;

    // DUT model with fault injection; a 2-state simulator cannot hold X, so fall back to an inverted bit
    always_comb begin
        g1 = (A & B) | C;
        g2 = A ^ B ^ C;
        F1 = f1_tie0 ? 1'b0 : g1;
        F2 = g2;
        if (f2_bad == int'({A, B, C}))
            F2 = (xv !== 1'b0 && xv !== 1'b1) ? xv : ~g2;
    end

    typedef struct {
        string name;
        logic  tie0;
        int    bad;
        int    restart_at;
        int    reset_at;
    } tv_t;

    typedef struct {
        int         cyc;
        logic [3:0] err;
        logic [7:0] fail;
        logic       pass;
        logic [2:0] vec;
    } exp_t;

    tv_t  tbl[7];
    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input tv_t v);
        exp_t r;
        logic bad;
        r.cyc = 40; r.err = 0; r.fail = 0; r.vec = 3'd7;
        for (int i = 0; i < 8; i++) begin
            bad = (v.tie0 && (((i >> 2) & (i >> 1) & 1) | (i & 1)) != 0) || (v.bad == i);
            if (bad) begin
                r.err++;
                r.fail[i] = 1'b1;
                if (STOP) begin
                    r.cyc = 5 * (i + 1);
                    r.vec = 3'(i);
                    break;
                end
            end
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic sweep(input tv_t v);
        exp_t e;
        bit   got = 0;
        f1_tie0 = v.tie0;
        f2_bad  = v.bad;
        q.push_back(model(v));
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            start = (c == v.restart_at);
            reset = (c == v.reset_at);
            @(posedge clk); #1;
            if (c == v.reset_at) begin
                chk({v.name, " rst abc"}, {A, B, C}, 0);
                chk({v.name, " rst busy/done/pass"}, {busy, done, pass}, 0);
                chk({v.name, " rst err"}, err_count, 0);
                chk({v.name, " rst fail"}, fail_vec, 0);
                void'(q.pop_front());
                @(negedge clk); reset = 1'b0;
                return;
            end
            if (done) begin
                got = 1;
                e = q.pop_front();
                chk({v.name, " done cycle"}, c, e.cyc);
                chk({v.name, " err_count"}, err_count, e.err);
                chk({v.name, " fail_vec"}, fail_vec, e.fail);
                chk({v.name, " pass"}, pass, e.pass);
                chk({v.name, " held abc"}, {A, B, C}, e.vec);
                chk({v.name, " busy at done"}, busy, 0);
            end else begin
                chk({v.name, " step busy/abc"}, {busy, A, B, C}, {1'b1, 3'((c < 40) ? c / 5 : 7)});
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: done never rose within 100 cycles", v.name);
            void'(q.pop_front());
        end
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"golden",    1'b0, -1,  0,  0};
        tbl[1] = '{"f1_tied0",  1'b1, -1,  0,  0};
        tbl[2] = '{"restart10", 1'b0, -1, 10,  0};
        tbl[3] = '{"reset_v3",  1'b0, -1,  0, 16};
        tbl[4] = '{"after_rst", 1'b0, -1,  0,  0};
        tbl[5] = '{"f2x_v5",    1'b0,  5,  0,  0};
        tbl[6] = '{"bad_v2",    1'b0,  2,  0,  0};
        repeat (2) @(posedge clk);
        #1;
        chk("reset abc", {A, B, C}, 0);
        chk("reset busy/done/pass", {busy, done, pass}, 0);
        chk("reset err/fail", {err_count, fail_vec}, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("idle no start", {busy, done}, 0);
        for (int t = 0; t < 7; t++) sweep(tbl[t]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
